// File: rtl/a23_cache_flush_ctrl.sv
// a23_cache_flush_ctrl: tag RAM invalidation sequencer and cacheable-region decoder
module a23_cache_flush_ctrl #(
   parameter int CACHE_LINES = 256,
   parameter int LINE_W      = $clog2(CACHE_LINES)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cache_enable,
   input  logic              i_cache_flush,
   input  logic [31:0]       i_cacheable_area,
   input  logic [31:0]       i_address,
   output logic              o_cacheable,
   output logic              o_flush_busy,
   output logic              o_flush_done,
   output logic              o_tag_wenable,
   output logic [LINE_W-1:0] o_tag_waddr,
   output logic [15:0]       o_flush_count
);
   typedef enum logic [1:0] {INIT, IDLE, FLUSH} state_t;

   state_t              state, state_n;
   logic [LINE_W-1:0]   line, line_n;
   logic                pending, pending_n, done_n;
   logic [15:0]         count_n;
   logic                sweep, last, restart;

   assign sweep   = state != IDLE;
   assign last    = line == LINE_W'(CACHE_LINES - 1);
   assign restart = pending | i_cache_flush;

   assign o_flush_busy  = i_rst | sweep;
   assign o_tag_wenable = !i_rst & sweep;
   assign o_tag_waddr   = o_tag_wenable ? line : '0;
   assign o_cacheable   = i_cache_enable & !o_flush_busy & (i_address[31:26] == 6'd0)
                          & i_cacheable_area[i_address[25:21]];

   // next sweep position; a request on the final line restarts instead of queueing
   always_comb begin
      state_n   = state;
      line_n    = '0;
      pending_n = pending;
      done_n    = 1'b0;
      count_n   = o_flush_count;
      if (sweep) begin
         line_n = line + 1'b1;
         if (last) begin
            state_n   = restart ? FLUSH : IDLE;
            pending_n = 1'b0;
            done_n    = (state == FLUSH) & !restart;
            count_n   = (state == FLUSH) ? o_flush_count + 16'd1 : o_flush_count;
         end else begin
            pending_n = pending | i_cache_flush;
         end
      end else if (i_cache_flush) begin
         state_n = FLUSH;
      end
   end

   // state register; reset abandons any sweep and restarts the power-on sweep
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= INIT;
         line          <= '0;
         pending       <= 1'b0;
         o_flush_done  <= 1'b0;
         o_flush_count <= 16'd0;
      end else begin
         state         <= state_n;
         line          <= line_n;
         pending       <= pending_n;
         o_flush_done  <= done_n;
         o_flush_count <= count_n;
      end
   end
endmodule

// File: tb/tb_a23_cache_flush_ctrl.sv
// tb_a23_cache_flush_ctrl: timestamp-based sweep model with random and directed stimulus
module tb_a23_cache_flush_ctrl;
   localparam int N = 256;
   localparam int W = 8;

   logic          clk = 1'b0, rst = 1'b1, en = 1'b0, flush = 1'b0;
   logic [31:0]   area = '0, addr = '0;
   logic          cacheable, busy, done, wen;
   logic [W-1:0]  waddr;
   logic [15:0]   fcount;

   a23_cache_flush_ctrl #(.CACHE_LINES(N)) dut (
      .i_clk(clk), .i_rst(rst), .i_cache_enable(en), .i_cache_flush(flush),
      .i_cacheable_area(area), .i_address(addr), .o_cacheable(cacheable),
      .o_flush_busy(busy), .o_flush_done(done), .o_tag_wenable(wen),
      .o_tag_waddr(waddr), .o_flush_count(fcount)
   );

   always #5 clk = ~clk;

   int  checks = 0, errors = 0, busy_cnt = 0, done_cnt = 0;
   int  cyc = 0, m_start = 0, m_idx, m_count = 0;
   bit  m_active = 1'b1, m_init = 1'b1, m_extra = 1'b0, m_done = 1'b0, go = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // model: a sweep is a start timestamp; the line written is elapsed cycles since then
   always @(posedge clk) begin
      m_idx = cyc - m_start;
      if (rst) begin
         m_active = 1'b1; m_init = 1'b1; m_start = cyc + 1;
         m_extra = 1'b0; m_count = 0; m_done = 1'b0;
      end else if (m_active) begin
         m_done = 1'b0;
         if (m_idx == N - 1) begin
            if (!m_init) m_count = (m_count + 1) % 65536;
            if (m_extra || flush) begin
               m_init = 1'b0; m_start = cyc + 1; m_extra = 1'b0;
            end else begin
               m_done = !m_init; m_active = 1'b0;
            end
         end else if (flush) begin
            m_extra = 1'b1;
         end
      end else begin
         m_done = 1'b0;
         if (flush) begin
            m_active = 1'b1; m_init = 1'b0; m_start = cyc + 1;
         end
      end
      cyc++;
   end

   // compare every cycle, mid-period
   always @(negedge clk) begin
      if (go) begin
         logic e_busy, e_wen, e_cache;
         e_busy  = rst | m_active;
         e_wen   = !rst & m_active;
         e_cache = en & !e_busy & (addr[31:26] == 6'd0) & area[addr[25:21]];
         chk("busy", busy, e_busy);
         chk("wen", wen, e_wen);
         chk("waddr", waddr, e_wen ? (cyc - m_start) : 0);
         chk("done", done, m_done);
         chk("count", fcount, m_count);
         chk("cacheable", cacheable, e_cache);
         busy_cnt += busy;
         done_cnt += done;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle();
      int i = 0;
      while (m_active && i < 3000) begin
         step(1);
         i++;
      end
      if (i >= 3000) begin
         checks++; errors++;
         $display("FAIL wait_idle: timeout after %0d cycles", i);
      end
   endtask

   task automatic at_line(input int k);
      int i = 0;
      while (!(m_active && !rst && (cyc - m_start) == k) && i < 3000) begin
         step(1);
         i++;
      end
      if (i >= 3000) begin
         checks++; errors++;
         $display("FAIL at_line %0d: timeout", k);
      end
   endtask

   task automatic pulse();
      flush = 1'b1;
      step(1);
      flush = 1'b0;
   endtask

   task automatic clr();
      busy_cnt = 0;
      done_cnt = 0;
   endtask

   initial begin
      @(posedge clk);
      #1 go = 1'b1;
      step(2);
      rst = 1'b0;
      clr();
      wait_idle(); step(2);
      chk("reset_sweep_busy_cycles", busy_cnt, N);
      chk("reset_sweep_no_done", done_cnt, 0);
      chk("reset_sweep_count", fcount, 0);

      pulse();
      clr();
      chk("flush_busy_next_cycle", busy, 1);
      chk("flush_first_line", waddr, 0);
      wait_idle(); step(2);
      chk("single_busy_cycles", busy_cnt, N);
      chk("single_done", done_cnt, 1);
      chk("single_count", fcount, 1);

      pulse();
      clr();
      at_line(10); pulse();
      at_line(200); pulse();
      wait_idle(); step(2);
      chk("collapse_busy_cycles", busy_cnt, 2 * N);
      chk("collapse_done", done_cnt, 1);
      chk("collapse_count", fcount, 3);

      pulse();
      clr();
      at_line(N - 1); pulse();
      chk("restart_line0", waddr, 0);
      chk("restart_busy", busy, 1);
      wait_idle(); step(2);
      chk("restart_busy_cycles", busy_cnt, 2 * N);
      chk("restart_done", done_cnt, 1);
      chk("restart_count", fcount, 5);

      en = 1'b1; area = 32'h0000_0005;
      addr = 32'h0010_0000; #1 chk("area_region0", cacheable, 1);
      addr = 32'h0020_0000; #1 chk("area_region1", cacheable, 0);
      addr = 32'h0040_0000; #1 chk("area_region2", cacheable, 1);
      addr = 32'h0400_0000; #1 chk("area_above_64mb", cacheable, 0);
      addr = 32'h0010_0000;
      pulse();
      chk("area_while_busy", cacheable, 0);
      wait_idle(); step(2);

      pulse();
      at_line(50); pulse();
      at_line(100);
      rst = 1'b1;
      step(1);
      chk("rst_mid_wen", wen, 0);
      chk("rst_mid_busy", busy, 1);
      rst = 1'b0;
      clr();
      wait_idle(); step(2);
      chk("rst_mid_busy_cycles", busy_cnt, N);
      chk("rst_mid_done", done_cnt, 0);
      chk("rst_mid_count", fcount, 0);

      for (int i = 0; i < 4000; i++) begin
         flush = $urandom_range(0, 99) < 2;
         rst   = $urandom_range(0, 999) == 0;
         en    = $urandom_range(0, 3) != 0;
         area  = $urandom;
         addr  = $urandom_range(0, 1) ? ($urandom & 32'h07FF_FFFF) : $urandom;
         step(1);
      end
      flush = 1'b0; rst = 1'b0;
      wait_idle(); step(2);
      go = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
